id_ex_stage: RTL and testbench

ID/EX boundary of the 5-stage RV32I pipeline. It captures decode-stage operands and control into execute-stage registers and bypasses same-cycle writeback data onto the operand paths. It also detects load-use hazards, generates stall/flush controls for the F, D and E stages, and keeps two saturating hazard counters. It consumes the register-file read data and the writeback port signals.

---
 rtl/id_ex_stage.sv | 183 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline boundary of the RV32I core.
// Registers decode operands/control into E and bypasses same-cycle writeback data.
// It also raises load-use stall and branch flush controls and keeps two
// saturating hazard counters.
// Optional feature macro: ID_WB_BYPASS_EN. When it is defined, the W-port data is
// bypassed onto the operands. When it is undefined, the register file must provide
// write-first reads.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            ALUSrcD,
  input  logic            BranchD,
  input  logic            JumpD,
  input  logic [1:0]      ResultSrcD,
  input  logic [2:0]      ALUControlD,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            PCSrcE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            ALUSrcE,
  output logic            BranchE,
  output logic            JumpE,
  output logic            ValidE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic            FlushE,
  output logic [31:0]     StallCount,
  output logic [31:0]     FlushCount
);

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_write;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic            valid;
    logic [1:0]      result_src;
    logic [2:0]      alu_control;
  } e_reg_t;

  e_reg_t          e_q, e_d;
  logic [31:0]     stall_count_q, stall_count_d;
  logic [31:0]     flush_count_q, flush_count_d;
  logic [XLEN-1:0] op_a, op_b;
  logic            lw_stall;
  logic            stall_d;
  logic            flush_e;

`ifdef ID_WB_BYPASS_EN
  logic fwd1, fwd2;

  // Forward the writeback result when W writes the register D is reading (never x0)
  always_comb begin
    fwd1 = RegWriteW && (RdW != 5'd0) && (RdW == Rs1D);
    fwd2 = RegWriteW && (RdW != 5'd0) && (RdW == Rs2D);
    op_a = fwd1 ? ResultW : RD1D;
    op_b = fwd2 ? ResultW : RD2D;
  end
`else
  logic unused_w_port;

  // Register file is write-first, so its read data is already current
  always_comb begin
    op_a          = RD1D;
    op_b          = RD2D;
    unused_w_port = ^{RegWriteW, RdW, ResultW};
  end
`endif

  // Load-use hazard detection; a taken branch/jump overrides the stall with a flush
  always_comb begin
    lw_stall = (e_q.result_src == 2'b01) && e_q.valid && (e_q.rd != 5'd0) &&
               ((e_q.rd == Rs1D) || (e_q.rd == Rs2D));
    stall_d  = lw_stall && !PCSrcE;
    flush_e  = lw_stall || PCSrcE;
  end

  // Next E contents: a zeroed bubble on flush, otherwise capture of the D fields
  always_comb begin
    e_d = '0;
    if (!flush_e) begin
      e_d.rd1         = op_a;
      e_d.rd2         = op_b;
      e_d.imm         = ImmExtD;
      e_d.pc          = PCD;
      e_d.pc_plus4    = PCPlus4D;
      e_d.rs1         = Rs1D;
      e_d.rs2         = Rs2D;
      e_d.rd          = RdD;
      e_d.reg_write   = RegWriteD;
      e_d.mem_write   = MemWriteD;
      e_d.alu_src     = ALUSrcD;
      e_d.branch      = BranchD;
      e_d.jump        = JumpD;
      e_d.valid       = 1'b1;
      e_d.result_src  = ResultSrcD;
      e_d.alu_control = ALUControlD;
    end
  end

  // Saturating event counters: stall cycles and taken-branch flush cycles
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall_d && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
    if (PCSrcE && (flush_count_q != 32'hFFFF_FFFF)) begin
      flush_count_d = flush_count_q + 32'd1;
    end
  end

  // E register and counters; the E register never stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q           <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      e_q           <= e_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign RD1E        = e_q.rd1;
  assign RD2E        = e_q.rd2;
  assign ImmExtE     = e_q.imm;
  assign PCE         = e_q.pc;
  assign PCPlus4E    = e_q.pc_plus4;
  assign Rs1E        = e_q.rs1;
  assign Rs2E        = e_q.rs2;
  assign RdE         = e_q.rd;
  assign RegWriteE   = e_q.reg_write;
  assign MemWriteE   = e_q.mem_write;
  assign ALUSrcE     = e_q.alu_src;
  assign BranchE     = e_q.branch;
  assign JumpE       = e_q.jump;
  assign ValidE      = e_q.valid;
  assign ResultSrcE  = e_q.result_src;
  assign ALUControlE = e_q.alu_control;
  assign StallF      = stall_d;
  assign StallD      = stall_d;
  assign FlushD      = PCSrcE;
  assign FlushE      = flush_e;
  assign StallCount  = stall_count_q;
  assign FlushCount  = flush_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage. Expected E contents are pushed
// when D inputs are driven and popped after the capturing edge. Bypass expectations
// follow the ID_WB_BYPASS_EN macro of the build.
module tb_id_ex_stage;

  logic        clk, rst;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D, ResultW;
  logic [4:0]  Rs1D, Rs2D, RdD, RdW;
  logic        RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD, RegWriteW, PCSrcE;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ValidE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic        StallF, StallD, FlushD, FlushE;
  logic [31:0] StallCount, FlushCount;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .RD1D(RD1D), .RD2D(RD2D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
    .BranchD(BranchD), .JumpD(JumpD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .PCSrcE(PCSrcE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
    .BranchE(BranchE), .JumpE(JumpE), .ValidE(ValidE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd1, rd2, imm, pc, pcp4;
    logic [4:0]  rs1, rs2, rd;
    logic        regw, memw, alusrc, branch, jump, valid;
    logic [1:0]  rsrc;
    logic [2:0]  aluc;
  } e_t;

  e_t          exp_q[$];
  e_t          model_e;
  logic [31:0] model_stall, model_flush;
  int          checks, passes, txn;

  function automatic e_t observed_e();
    e_t o;
    o = '{RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
          RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ValidE, ResultSrcE, ALUControlE};
    return o;
  endfunction

  function automatic logic model_lw();
    return (model_e.rsrc == 2'b01) && model_e.valid && (model_e.rd != 5'd0) &&
           ((model_e.rd == Rs1D) || (model_e.rd == Rs2D));
  endfunction

  // Expected {StallF, StallD, FlushD, FlushE} for the current inputs
  function automatic logic [3:0] model_haz();
    logic lw;
    lw = model_lw();
    return {lw & ~PCSrcE, lw & ~PCSrcE, PCSrcE, lw | PCSrcE};
  endfunction

  // Compute the expected E contents for the driven inputs, queue them, clock once
  task automatic advance();
    e_t   nx;
    logic lw;
    lw = model_lw();
    nx = '0;
    if (!rst && !(lw || PCSrcE)) begin
`ifdef ID_WB_BYPASS_EN
      nx.rd1 = (RegWriteW && RdW != 5'd0 && RdW == Rs1D) ? ResultW : RD1D;
      nx.rd2 = (RegWriteW && RdW != 5'd0 && RdW == Rs2D) ? ResultW : RD2D;
`else
      nx.rd1 = RD1D;
      nx.rd2 = RD2D;
`endif
      nx.imm = ImmExtD; nx.pc = PCD; nx.pcp4 = PCPlus4D;
      nx.rs1 = Rs1D; nx.rs2 = Rs2D; nx.rd = RdD;
      nx.regw = RegWriteD; nx.memw = MemWriteD; nx.alusrc = ALUSrcD;
      nx.branch = BranchD; nx.jump = JumpD; nx.valid = 1'b1;
      nx.rsrc = ResultSrcD; nx.aluc = ALUControlD;
    end
    exp_q.push_back(nx);
    if (rst) begin
      model_stall = '0;
      model_flush = '0;
    end else begin
      if (lw && !PCSrcE && model_stall != 32'hFFFF_FFFF) model_stall = model_stall + 1;
      if (PCSrcE && model_flush != 32'hFFFF_FFFF) model_flush = model_flush + 1;
    end
    $display("txn %0d: rst=%0b pcsrc=%0b lw=%0b rs1=%0d rs2=%0d rd=%0d valid_next=%0b",
             txn, rst, PCSrcE, lw, Rs1D, Rs2D, RdD, nx.valid);
    txn++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    RD1D = 32'h0; RD2D = 32'h0; ImmExtD = 32'h0; PCD = 32'h0; PCPlus4D = 32'h4;
    Rs1D = 5'd0; Rs2D = 5'd0; RdD = 5'd0;
    RegWriteD = 0; MemWriteD = 0; ALUSrcD = 0; BranchD = 0; JumpD = 0;
    ResultSrcD = 2'b00; ALUControlD = 3'd0;
    RegWriteW = 0; RdW = 5'd0; ResultW = 32'h0; PCSrcE = 0;
  endtask

  task automatic rand_d(input int reg_max);
    RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom; PCD = $urandom; PCPlus4D = $urandom;
    Rs1D = 5'($urandom_range(0, reg_max)); Rs2D = 5'($urandom_range(0, reg_max));
    RdD = 5'($urandom_range(0, reg_max));
    RegWriteD = 1'($urandom); MemWriteD = 1'($urandom); ALUSrcD = 1'($urandom);
    BranchD = 1'($urandom); JumpD = 1'($urandom);
    ResultSrcD = 2'($urandom); ALUControlD = 3'($urandom);
    RegWriteW = 1'($urandom); RdW = 5'($urandom_range(0, reg_max)); ResultW = $urandom;
  endtask

  task automatic test_reset();
    e_t got, exp;
    rst = 1'b1;
    PCSrcE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_d(31);
      advance();
      got = observed_e(); exp = exp_q.pop_front(); model_e = exp;
      checks++;
      if (got !== exp) $display("FAIL reset_e: got %h expected %h", got, exp);
      else passes++;
    end
    PCSrcE = 1'b0;
    #1;
    checks++;
    if ({StallCount, FlushCount} !== 64'h0)
      $display("FAIL reset_counters: got %h/%h expected 0/0", StallCount, FlushCount);
    else passes++;
    checks++;
    if ({StallF, FlushE} !== 2'b00) $display("FAIL reset_hazards: got %b expected 00", {StallF, FlushE});
    else passes++;
    rst = 1'b0;
  endtask

  task automatic test_bypass();
    e_t          got, exp;
    logic [31:0] req;
    clear_d();
    Rs1D = 5'd5; RD1D = 32'h11; Rs2D = 5'd6; RD2D = 32'h22; RdD = 5'd9;
    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hABCD;
`ifdef ID_WB_BYPASS_EN
    req = 32'hABCD;
`else
    req = 32'h11;
`endif
    advance();
    got = observed_e(); exp = exp_q.pop_front(); model_e = exp;
    checks++;
    if (got !== exp) $display("FAIL bypass_e: got %h expected %h", got, exp);
    else passes++;
    checks++;
    if (RD1E !== req) $display("FAIL bypass_rd1: got %h expected %h", RD1E, req);
    else passes++;
    checks++;
    if (RD2E !== 32'h22) $display("FAIL bypass_rd2_nomatch: got %h expected 00000022", RD2E);
    else passes++;
    // x0 is never bypassed, even when W targets x0
    Rs1D = 5'd0; RdW = 5'd0; RD1D = 32'h33;
    advance();
    got = observed_e(); exp = exp_q.pop_front(); model_e = exp;
    checks++;
    if (RD1E !== 32'h33) $display("FAIL bypass_x0: got %h expected 00000033", RD1E);
    else passes++;
    checks++;
    if (got !== exp) $display("FAIL bypass_x0_e: got %h expected %h", got, exp);
    else passes++;
  endtask

  task automatic test_load_use();
    e_t          got, exp;
    logic [31:0] sb;
    clear_d();
    RdD = 5'd7; ResultSrcD = 2'b01; RegWriteD = 1'b1; Rs1D = 5'd1; Rs2D = 5'd2;
    advance();
    got = observed_e(); exp = exp_q.pop_front(); model_e = exp;
    checks++;
    if (got !== exp) $display("FAIL load_e: got %h expected %h", got, exp);
    else passes++;
    clear_d();
    Rs1D = 5'd3; Rs2D = 5'd7; RdD = 5'd8; RegWriteD = 1'b1;
    #1;
    checks++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b1101)
      $display("FAIL loaduse_haz: got %b expected 1101", {StallF, StallD, FlushD, FlushE});
    else passes++;
    sb = model_stall;
    advance();
    got = observed_e(); exp = exp_q.pop_front(); model_e = exp;
    checks++;
    if ({ValidE, RegWriteE} !== 2'b00 || got !== exp)
      $display("FAIL loaduse_bubble: got %h expected %h", got, exp);
    else passes++;
    checks++;
    if (StallCount !== sb + 1) $display("FAIL loaduse_count: got %0d expected %0d", StallCount, sb + 1);
    else passes++;
    #1;
    checks++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0000)
      $display("FAIL loaduse_release: got %b expected 0000", {StallF, StallD, FlushD, FlushE});
    else passes++;
    advance();
    got = observed_e(); exp = exp_q.pop_front(); model_e = exp;
    checks++;
    if (ValidE !== 1'b1 || got !== exp) $display("FAIL loaduse_resume: got %h expected %h", got, exp);
    else passes++;
  endtask

  task automatic test_branch_flush();
    e_t          got, exp;
    logic [31:0] fb;
    clear_d();
    Rs1D = 5'd4; RdD = 5'd10; RegWriteD = 1'b1; PCSrcE = 1'b1;
    #1;
    checks++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0011)
      $display("FAIL branch_haz: got %b expected 0011", {StallF, StallD, FlushD, FlushE});
    else passes++;
    fb = model_flush;
    advance();
    PCSrcE = 1'b0;
    got = observed_e(); exp = exp_q.pop_front(); model_e = exp;
    checks++;
    if (ValidE !== 1'b0 || got !== exp) $display("FAIL branch_bubble: got %h expected %h", got, exp);
    else passes++;
    checks++;
    if (FlushCount !== fb + 1) $display("FAIL branch_count: got %0d expected %0d", FlushCount, fb + 1);
    else passes++;
  endtask

  task automatic test_simultaneous();
    e_t          got, exp;
    logic [31:0] sb, fb;
    clear_d();
    RdD = 5'd7; ResultSrcD = 2'b01; RegWriteD = 1'b1;
    advance();
    got = observed_e(); exp = exp_q.pop_front(); model_e = exp;
    checks++;
    if (got !== exp) $display("FAIL simul_load_e: got %h expected %h", got, exp);
    else passes++;
    clear_d();
    Rs1D = 5'd7; PCSrcE = 1'b1;
    #1;
    checks++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0011)
      $display("FAIL simul_haz: got %b expected 0011", {StallF, StallD, FlushD, FlushE});
    else passes++;
    sb = model_stall; fb = model_flush;
    advance();
    PCSrcE = 1'b0;
    got = observed_e(); exp = exp_q.pop_front(); model_e = exp;
    checks++;
    if (got !== exp) $display("FAIL simul_bubble: got %h expected %h", got, exp);
    else passes++;
    checks++;
    if (StallCount !== sb || FlushCount !== fb + 1)
      $display("FAIL simul_counts: got %0d/%0d expected %0d/%0d", StallCount, FlushCount, sb, fb + 1);
    else passes++;
  endtask

  task automatic test_back_to_back();
    e_t         got, exp;
    logic [3:0] hz;
    for (int i = 0; i < 40; i++) begin
      rand_d(3);
      PCSrcE = ($urandom_range(0, 5) == 0);
      #1;
      hz = model_haz();
      checks++;
      if ({StallF, StallD, FlushD, FlushE} !== hz)
        $display("FAIL b2b_haz[%0d]: got %b expected %b", i, {StallF, StallD, FlushD, FlushE}, hz);
      else passes++;
      advance();
      got = observed_e(); exp = exp_q.pop_front(); model_e = exp;
      checks++;
      if (got !== exp) $display("FAIL b2b_e[%0d]: got %h expected %h", i, got, exp);
      else passes++;
      checks++;
      if (StallCount !== model_stall || FlushCount !== model_flush)
        $display("FAIL b2b_counts[%0d]: got %0d/%0d expected %0d/%0d",
                 i, StallCount, FlushCount, model_stall, model_flush);
      else passes++;
    end
    PCSrcE = 1'b0;
  endtask

  task automatic test_saturation();
    e_t got, exp;
    clear_d();
    force dut.flush_count_q = 32'hFFFF_FFFE;
    advance();
    release dut.flush_count_q;
    got = observed_e(); exp = exp_q.pop_front(); model_e = exp;
    model_flush = 32'hFFFF_FFFE;
    checks++;
    if (FlushCount !== 32'hFFFF_FFFE) $display("FAIL sat_preload: got %h expected fffffffe", FlushCount);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      clear_d();
      PCSrcE = 1'b1;
      advance();
      got = observed_e(); exp = exp_q.pop_front(); model_e = exp;
      checks++;
      if (FlushCount !== 32'hFFFF_FFFF || FlushCount !== model_flush)
        $display("FAIL sat_hold[%0d]: got %h expected ffffffff", i, FlushCount);
      else passes++;
      checks++;
      if (got !== exp) $display("FAIL sat_e[%0d]: got %h expected %h", i, got, exp);
      else passes++;
    end
    PCSrcE = 1'b0;
  endtask

  initial begin
    checks = 0; passes = 0; txn = 0;
    model_e = '0; model_stall = '0; model_flush = '0;
    rst = 1'b1;
    clear_d();
    test_reset();
    test_bypass();
    test_load_use();
    test_branch_flush();
    test_simultaneous();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
